// File: rtl/counter_modn_updn.sv
// ---------------------------------------------------------------------------
// counter_modn_updn
//
// Modulo-M up/down counter with a runtime-programmable modulus. It supports
// wrap or saturate mode, a synchronous load and a registered one-cycle
// terminal-count pulse. M resets to N_DEFAULT. A host or sequencing FSM can
// retune M with a write strobe without resynthesis.
//
// Parameters:
//   WIDTH      width of the count, load and modulus buses
//   N_DEFAULT  modulus after reset, legal range 2..2^WIDTH-1
//
// Ports:
//   i_clk     clock, rising-edge active
//   i_rst_n   asynchronous active-low reset
//   i_en      count enable
//   i_ld      synchronous load of i_data (dominates everything else)
//   i_data    load value, clipped to M-1 when out of range
//   i_up      direction, 1 = increment, 0 = decrement
//   i_sat     mode, 1 = saturate at the range limits, 0 = wrap
//   i_mod_wr  modulus write strobe (writes below 2 are ignored)
//   i_mod     new modulus value
//   o_data    current count, 0..M-1
//   o_tc      registered terminal-count pulse
//   o_mod     current modulus M
// ---------------------------------------------------------------------------
module counter_modn_updn #(
    parameter int WIDTH     = 8,
    parameter int N_DEFAULT = 21
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_up,
    input  logic             i_sat,
    input  logic             i_mod_wr,
    input  logic [WIDTH-1:0] i_mod,
    output logic [WIDTH-1:0] o_data,
    output logic             o_tc,
    output logic [WIDTH-1:0] o_mod
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] mod_d;
    logic             tc_q;
    logic             tc_d;

    logic             mod_valid;
    logic [WIDTH-1:0] mod_eff;
    logic [WIDTH-1:0] mod_max;

    // A valid modulus write is visible to every decision on the same edge.
    // So the load clip, the clamp and the wrap limit all use mod_eff, not mod_q.
    // M is at least 2, so mod_max = M-1 never underflows.
    always_comb begin
        mod_valid = i_mod_wr && (i_mod >= WIDTH'(2));
        mod_eff   = mod_valid ? i_mod : mod_q;
        mod_max   = mod_eff - WIDTH'(1);
        mod_d     = mod_eff;
    end

    // Next count and terminal-count pulse, in priority order:
    // load, then clamp after a modulus shrink, then count, then hold.
    // In saturate mode the pulse marks arrival at a limit by counting.
    // Sitting at the limit only holds the value.
    always_comb begin
        data_d = data_q;
        tc_d   = 1'b0;
        if (i_ld) begin
            data_d = (i_data < mod_eff) ? i_data : mod_max;
        end else if (mod_valid && (data_q >= mod_eff)) begin
            data_d = '0;
        end else if (i_en) begin
            if (i_up) begin
                if (data_q < mod_max) begin
                    data_d = data_q + WIDTH'(1);
                    tc_d   = i_sat && (data_q == (mod_max - WIDTH'(1)));
                end else if (!i_sat) begin
                    data_d = '0;
                    tc_d   = 1'b1;
                end
            end else begin
                if (data_q != '0) begin
                    data_d = data_q - WIDTH'(1);
                    tc_d   = i_sat && (data_q == WIDTH'(1));
                end else if (!i_sat) begin
                    data_d = mod_max;
                    tc_d   = 1'b1;
                end
            end
        end
    end

    // Output registers. Reset aborts any count in progress and restores
    // the default modulus at once, without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
            tc_q   <= 1'b0;
            mod_q  <= WIDTH'(N_DEFAULT);
        end else begin
            data_q <= data_d;
            tc_q   <= tc_d;
            mod_q  <= mod_d;
        end
    end

    assign o_data = data_q;
    assign o_tc   = tc_q;
    assign o_mod  = mod_q;

endmodule

// File: tb/tb_counter_modn_updn.sv
// ---------------------------------------------------------------------------
// tb_counter_modn_updn
//
// Directed test of counter_modn_updn with WIDTH=8 and N_DEFAULT=21.
// An integer reference model tracks count, modulus and pulse. It is compared
// on every falling edge. Hand-computed literal checks pin the model at key
// points of each scenario.
// ---------------------------------------------------------------------------
module tb_counter_modn_updn;

    localparam int WIDTH     = 8;
    localparam int N_DEFAULT = 21;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] data;
    logic             up;
    logic             sat;
    logic             mod_wr;
    logic [WIDTH-1:0] mod;
    logic [WIDTH-1:0] o_data;
    logic             o_tc;
    logic [WIDTH-1:0] o_mod;

    int n_checks = 0;
    int n_fails  = 0;

    int model_cnt;
    int model_mod;
    int model_tc;
    int next_mod;
    int limit;

    counter_modn_updn #(
        .WIDTH    (WIDTH),
        .N_DEFAULT(N_DEFAULT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_ld    (ld),
        .i_data  (data),
        .i_up    (up),
        .i_sat   (sat),
        .i_mod_wr(mod_wr),
        .i_mod   (mod),
        .o_data  (o_data),
        .o_tc    (o_tc),
        .o_mod   (o_mod)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model in plain integer arithmetic. Wrap mode counts modulo M.
    // Saturate mode steps toward the limit in the current direction and stops there.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt = 0;
            model_mod = N_DEFAULT;
            model_tc  = 0;
        end else begin
            next_mod = (mod_wr && int'(mod) >= 2) ? int'(mod) : model_mod;
            model_tc = 0;
            if (ld) begin
                model_cnt = (int'(data) >= next_mod) ? next_mod - 1 : int'(data);
            end else if (mod_wr && int'(mod) >= 2 && model_cnt >= next_mod) begin
                model_cnt = 0;
            end else if (en) begin
                if (!sat) begin
                    if (up) begin
                        model_cnt = (model_cnt + 1) % next_mod;
                        model_tc  = (model_cnt == 0) ? 1 : 0;
                    end else begin
                        model_cnt = (model_cnt + next_mod - 1) % next_mod;
                        model_tc  = (model_cnt == next_mod - 1) ? 1 : 0;
                    end
                end else begin
                    limit = up ? next_mod - 1 : 0;
                    if (model_cnt != limit) begin
                        model_cnt = up ? model_cnt + 1 : model_cnt - 1;
                        model_tc  = (model_cnt == limit) ? 1 : 0;
                    end
                end
            end
            model_mod = next_mod;
        end
    end

    // Check the DUT against the model on every cycle, away from the active edge
    always @(negedge clk) begin
        checkOutput("cmp_data", int'(o_data), model_cnt);
        checkOutput("cmp_tc", int'(o_tc), model_tc);
        checkOutput("cmp_mod", int'(o_mod), model_mod);
    end

    // Advance one rising edge, then settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one input vector and hold it for the given number of edges
    task automatic applyStimulus(input logic s_ld, input int s_data, input logic s_en,
                                 input logic s_up, input logic s_sat,
                                 input logic s_mod_wr, input int s_mod, input int cycles);
        ld     = s_ld;
        data   = WIDTH'(s_data);
        en     = s_en;
        up     = s_up;
        sat    = s_sat;
        mod_wr = s_mod_wr;
        mod    = WIDTH'(s_mod);
        repeat (cycles) tick();
    endtask

    // Literal check of all three outputs
    task automatic expectAll(input string name, input int e_data, input int e_tc, input int e_mod);
        checkOutput({name, "_data"}, int'(o_data), e_data);
        checkOutput({name, "_tc"}, int'(o_tc), e_tc);
        checkOutput({name, "_mod"}, int'(o_mod), e_mod);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
        expectAll("reset", 0, 0, 21);

        // Count to 9 after release, then reset between edges
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expectAll("first_edge", 1, 0, 21);
        repeat (8) tick();
        expectAll("count9", 9, 0, 21);
        #2;
        rst_n = 1'b0;
        #1;
        expectAll("async_reset", 0, 0, 21);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expectAll("after_release", 1, 0, 21);

        // Up wrap from 0
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 1);
        expectAll("load0", 0, 0, 21);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 20);
        expectAll("up20", 20, 0, 21);
        tick();
        expectAll("up_wrap", 0, 1, 21);
        tick();
        expectAll("up_after_wrap", 1, 0, 21);

        // Down wrap from 3
        applyStimulus(1, 3, 1, 1, 0, 0, 0, 1);
        expectAll("load3", 3, 0, 21);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 3);
        expectAll("down0", 0, 0, 21);
        tick();
        expectAll("down_wrap", 20, 1, 21);
        tick();
        expectAll("down_after_wrap", 19, 0, 21);

        // Saturate upward from 18
        applyStimulus(1, 18, 0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 1);
        expectAll("sat19", 19, 0, 21);
        tick();
        expectAll("sat_arrive", 20, 1, 21);
        repeat (5) tick();
        expectAll("sat_hold", 20, 0, 21);
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1);
        expectAll("sat_reverse", 19, 0, 21);

        // Saturate downward arrival at 0
        applyStimulus(1, 2, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 2);
        expectAll("sat_down_arrive", 0, 1, 21);
        tick();
        expectAll("sat_down_hold", 0, 0, 21);

        // Modulus write with clamp, wrap at the new M, ignored write of 1
        applyStimulus(1, 15, 0, 1, 0, 0, 0, 1);
        expectAll("load15", 15, 0, 21);
        applyStimulus(0, 0, 1, 1, 0, 1, 10, 1);
        expectAll("mod_clamp", 0, 0, 10);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 9);
        expectAll("mod_up9", 9, 0, 10);
        tick();
        expectAll("mod_wrap", 0, 1, 10);
        applyStimulus(0, 0, 1, 1, 0, 1, 1, 1);
        expectAll("mod_ignored", 1, 0, 10);
        applyStimulus(0, 0, 1, 1, 0, 1, 21, 1);
        expectAll("mod_restore", 2, 0, 21);

        // Load priority over enable, and load clip to M-1
        applyStimulus(1, 50, 1, 1, 0, 0, 0, 1);
        expectAll("load_clip", 20, 0, 21);
        applyStimulus(1, 7, 1, 1, 0, 0, 0, 1);
        expectAll("load_prio", 7, 0, 21);

        // A modulus write above the count keeps the count while disabled, and the new M then sets the wrap
        applyStimulus(1, 5, 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 8, 1);
        expectAll("mod_noclamp", 5, 0, 8);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 3);
        expectAll("mod8_wrap", 0, 1, 8);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 2);
        expectAll("hold", 0, 0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/counter_modn_updn.md
Name: counter_modn_updn

Overview:
Parametrised modulo-N counter with up/down direction, wrap or saturate mode, and a runtime-programmable modulus. It has a synchronous load and a one-cycle terminal-count pulse. It is the general-purpose successor counter for the iCESDM decimation, timing and readout sequencing logic. It replaces fixed-modulus up-only counters where a host or FSM must retune the period without resynthesis.

Parameters:
WIDTH, 8, width of the count, load and modulus buses.
N_DEFAULT, 21, modulus loaded at reset. Legal range is 2..2^WIDTH-1.

Ports:
i_clk  input  1  clock; all state changes on its rising edge.
i_rst_n  input  1  reset; asynchronous, active-low.
i_en  input  1  count enable.
i_ld  input  1  synchronous load of i_data.
i_data  input  WIDTH  load value.
i_up  input  1  direction: 1 = increment, 0 = decrement.
i_sat  input  1  mode: 1 = saturate at the range limits, 0 = wrap.
i_mod_wr  input  1  modulus write strobe.
i_mod  input  WIDTH  new modulus value.
o_data  output  WIDTH  current count, range 0..M-1 (M = effective modulus).
o_tc  output  1  registered terminal-count pulse.
o_mod  output  WIDTH  current modulus M.

Behaviour:
- Reset (i_rst_n=0, asynchronous): o_data=0, o_tc=0, o_mod=N_DEFAULT immediately. Reset mid-count aborts the count. The first count occurs on the first rising edge after i_rst_n deasserts.
- Modulus write: when i_mod_wr=1 and i_mod>=2, M takes i_mod at the edge. When i_mod<2, the write is ignored and M is unchanged. The effective M for all decisions in a cycle is the new value if a valid write occurs in that cycle.
- Per-edge priority: ld > mod-write clamp > count > hold.
- Load (i_ld=1): o_data <= i_data if i_data < M, else o_data <= M-1. o_tc <= 0. i_en is ignored that cycle.
- Mod-write clamp (no load): if the current o_data >= new M, then o_data <= 0 and o_tc <= 0, regardless of i_en.
- Count (i_en=1, no load, no clamp):
  - up, o_data < M-1: o_data+1.
  - up, o_data == M-1, wrap: o_data <= 0, o_tc <= 1.
  - up, o_data == M-1, saturate: hold, o_tc <= 0.
  - down, o_data > 0: o_data-1.
  - down, o_data == 0, wrap: o_data <= M-1, o_tc <= 1.
  - down, o_data == 0, saturate: hold, o_tc <= 0.
  - Saturate mode: o_tc <= 1 on the edge where o_data arrives at the limit (M-1 going up, 0 going down) by counting. Holding at the limit never re-asserts o_tc.
- Hold (i_en=0, no load, no clamp): o_data unchanged, o_tc <= 0.
- o_tc is high for exactly one cycle per event. It is coincident with the post-wrap or post-arrival o_data value.
- i_up and i_sat are sampled every edge. A direction or mode change takes effect on that same edge with no pipeline delay.
- All arithmetic is unsigned within WIDTH bits. No intermediate value exceeds 2^WIDTH-1.
- Latency: one clock from any input to o_data, o_tc and o_mod. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: count to 9, pull i_rst_n low between edges -> o_data=0, o_tc=0, o_mod=21 with no clock edge; release -> first edge gives o_data=1.
- Up wrap (en=1, up=1, sat=0, from 0): after 20 edges o_data=20; edge 21 -> o_data=0 and o_tc=1 for one cycle; edge 22 -> o_data=1, o_tc=0.
- Down wrap: load 3, then up=0 -> 2, 1, 0; next edge -> o_data=20 with o_tc=1; next edge -> 19, o_tc=0.
- Saturate: load 18, sat=1, up=1 -> 19, 20 (o_tc=1), then 20 held with o_tc=0 for 5 edges; set up=0 -> 19 on the next edge.
- Modulus write: at o_data=15, write i_mod=10 -> o_mod=10, o_data=0; count wraps 9 -> 0 with o_tc=1. Write i_mod=1 -> o_mod stays 10 and the count is unaffected.
- Load priority and clamp: ld=1, en=1, i_data=50 with M=21 -> o_data=20, o_tc=0. ld=1, en=1, i_data=7 -> o_data=7, not 8.
